// File: rtl/output_tensor_writer_pkg.sv
// Shared types and constants for the output tensor write-back path.
package output_tensor_writer_pkg;

  localparam int unsigned TILE_DIM   = 4;
  localparam int unsigned TILE_BYTES = TILE_DIM * TILE_DIM;

  typedef logic signed [7:0] int8_t;

  // One tile row: element j is channel j of the group.
  typedef int8_t [0:TILE_DIM-1] tile_row_t;
  // Whole tile: row i is pixel i of the group.
  typedef tile_row_t [0:TILE_DIM-1] tile_t;

  // Clamp a signed byte at zero.
  function automatic int8_t relu8(input int8_t v);
    return v[7] ? 8'sd0 : v;
  endfunction

endpackage

// File: rtl/output_addr_gen.sv
// Tile position counters, live-slot mask and channel-last byte address
// generation for the output tensor writer.
module output_addr_gen
  import output_tensor_writer_pkg::*;
#(
  parameter int unsigned PIX_W  = 11,
  parameter int unsigned CH_W   = 7,
  parameter int unsigned CHB_W  = 7,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  input  logic [PIX_W-1:0]  total_pix,
  input  logic [CH_W-1:0]   channels,
  input  logic [1:0]        slot_pix,
  input  logic [1:0]        slot_ch,
  output logic              live_c,
  output logic [ADDR_W-1:0] addr_c,
  output logic              layer_end_c
);

  logic [PIX_W-1:0] pix_base;
  logic [PIX_W-1:0] pix_idx;
  logic [PIX_W-1:0] pix_next;
  logic [CHB_W-1:0] ch_base;
  logic [CHB_W-1:0] ch_idx;
  logic [CHB_W-1:0] ch_next;
  logic [CHB_W-1:0] ch_lim;
  logic             pix_wrap;

  // Slot position, liveness, address and end-of-layer lookahead.
  always_comb begin
    ch_lim      = CHB_W'(channels);
    pix_idx     = pix_base + PIX_W'(slot_pix);
    ch_idx      = ch_base + CHB_W'(slot_ch);
    live_c      = (pix_idx < total_pix) && (ch_idx < ch_lim);
    addr_c      = ADDR_W'(pix_idx) * ADDR_W'(channels) + ADDR_W'(ch_idx);
    pix_next    = pix_base + PIX_W'(TILE_DIM);
    ch_next     = ch_base + CHB_W'(TILE_DIM);
    pix_wrap    = (pix_next >= total_pix);
    layer_end_c = pix_wrap && (ch_next >= ch_lim);
  end

  // Pixel tiles innermost, channel groups outermost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_base <= '0;
      ch_base  <= '0;
    end else if (clear) begin
      pix_base <= '0;
      ch_base  <= '0;
    end else if (advance) begin
      if (pix_wrap) begin
        pix_base <= '0;
        ch_base  <= ch_next;
      end else begin
        pix_base <= pix_next;
      end
    end
  end

endmodule

// File: rtl/output_tensor_writer.sv
// Output tensor writer: takes 4x4 int8 result tiles (4 pixels x 4 channels)
// and serialises them as byte writes into a channel-last [row, col, channel]
// tensor_ram, one slot per cycle, pulsing layer_done after the last tile.
// Optional build macro OUTPUT_WRITER_RELU_EN: negative bytes are clamped to 0
// at tile capture; timing is unchanged.
module output_tensor_writer
  import output_tensor_writer_pkg::*;
#(
  parameter int unsigned MAX_IMG_W    = 32,
  parameter int unsigned MAX_IMG_H    = 32,
  parameter int unsigned MAX_CHANNELS = 64,
  parameter int unsigned ADDR_W       = $clog2(MAX_IMG_W*MAX_IMG_H*MAX_CHANNELS)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [$clog2(MAX_IMG_W+1)-1:0]    out_width,
  input  logic [$clog2(MAX_IMG_H+1)-1:0]    out_height,
  input  logic [$clog2(MAX_CHANNELS+1)-1:0] out_channels,
  input  logic                              tile_valid,
  output logic                              tile_ready,
  input  int8_t [0:TILE_DIM-1]              C0,
  input  int8_t [0:TILE_DIM-1]              C1,
  input  int8_t [0:TILE_DIM-1]              C2,
  input  int8_t [0:TILE_DIM-1]              C3,
  output logic                              ram_we,
  output logic [ADDR_W-1:0]                 ram_addr_w,
  output logic [7:0]                        ram_din,
  output logic                              busy,
  output logic                              layer_done
);

  localparam int unsigned CH_W   = $clog2(MAX_CHANNELS + 1);
  localparam int unsigned CHB_W  = $clog2(MAX_CHANNELS + TILE_DIM + 1);
  localparam int unsigned PIX_W  = $clog2(MAX_IMG_W*MAX_IMG_H + TILE_DIM + 1);
  localparam int unsigned SLOT_W = $clog2(TILE_BYTES + 1);

  typedef enum logic [1:0] {IDLE, WAIT_TILE, WRITE, DONE} state_t;

  state_t              state, state_n;
  logic [SLOT_W-1:0]   slot, slot_n;
  tile_t               buffer, buf_n;
  logic [PIX_W-1:0]    total_pix, total_pix_n;
  logic [CH_W-1:0]     channels, channels_n;
  logic                tile_ready_n;
  logic                ram_we_n;
  logic [ADDR_W-1:0]   ram_addr_n;
  logic [7:0]          ram_din_n;
  logic                busy_n;
  logic                layer_done_n;

  logic                clear_c;
  logic                advance_c;
  logic [3:0]          slot_sel_c;
  logic                live_c;
  logic [ADDR_W-1:0]   addr_c;
  logic                layer_end_c;

  // Byte conditioning applied when a tile is captured.
  function automatic int8_t capture_byte(input int8_t b);
`ifdef OUTPUT_WRITER_RELU_EN
    return relu8(b);
`else
    return b;
`endif
  endfunction

  // Slot 0 is emitted on the handshake edge itself, before it sits in the buffer.
  assign slot_sel_c = (state == WAIT_TILE) ? 4'd0 : slot[3:0];

  output_addr_gen #(
    .PIX_W  (PIX_W),
    .CH_W   (CH_W),
    .CHB_W  (CHB_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear_c),
    .advance     (advance_c),
    .total_pix   (total_pix),
    .channels    (channels),
    .slot_pix    (slot_sel_c[3:2]),
    .slot_ch     (slot_sel_c[1:0]),
    .live_c      (live_c),
    .addr_c      (addr_c),
    .layer_end_c (layer_end_c)
  );

  // Next-state and next-output computation for the write-back sequencer.
  always_comb begin
    state_n      = state;
    slot_n       = slot;
    buf_n        = buffer;
    total_pix_n  = total_pix;
    channels_n   = channels;
    tile_ready_n = 1'b0;
    ram_we_n     = 1'b0;
    ram_addr_n   = ram_addr_w;
    ram_din_n    = ram_din;
    busy_n       = busy;
    layer_done_n = 1'b0;
    clear_c      = 1'b0;
    advance_c    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          total_pix_n = PIX_W'(out_width) * PIX_W'(out_height);
          channels_n  = out_channels;
          busy_n      = 1'b1;
          clear_c     = 1'b1;
          if ((out_width == '0) || (out_height == '0) || (out_channels == '0)) begin
            state_n      = DONE;
            layer_done_n = 1'b1;
          end else begin
            state_n      = WAIT_TILE;
            tile_ready_n = 1'b1;
          end
        end
      end

      WAIT_TILE: begin
        tile_ready_n = 1'b1;
        if (tile_valid && tile_ready) begin
          for (int j = 0; j < TILE_DIM; j++) begin
            buf_n[0][j] = capture_byte(C0[j]);
            buf_n[1][j] = capture_byte(C1[j]);
            buf_n[2][j] = capture_byte(C2[j]);
            buf_n[3][j] = capture_byte(C3[j]);
          end
          ram_we_n     = live_c;
          ram_addr_n   = addr_c;
          ram_din_n    = buf_n[0][0];
          slot_n       = SLOT_W'(1);
          tile_ready_n = 1'b0;
          state_n      = WRITE;
        end
      end

      WRITE: begin
        if (slot == SLOT_W'(TILE_BYTES)) begin
          advance_c = 1'b1;
          if (layer_end_c) begin
            state_n      = DONE;
            layer_done_n = 1'b1;
          end else begin
            state_n      = WAIT_TILE;
            tile_ready_n = 1'b1;
          end
        end else begin
          ram_we_n   = live_c;
          ram_addr_n = addr_c;
          ram_din_n  = buffer[slot[3:2]][slot[1:0]];
          slot_n     = slot + SLOT_W'(1);
        end
      end

      DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  // State, buffer, latched config and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      slot       <= '0;
      buffer     <= '0;
      total_pix  <= '0;
      channels   <= '0;
      tile_ready <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr_w <= '0;
      ram_din    <= '0;
      busy       <= 1'b0;
      layer_done <= 1'b0;
    end else begin
      state      <= state_n;
      slot       <= slot_n;
      buffer     <= buf_n;
      total_pix  <= total_pix_n;
      channels   <= channels_n;
      tile_ready <= tile_ready_n;
      ram_we     <= ram_we_n;
      ram_addr_w <= ram_addr_n;
      ram_din    <= ram_din_n;
      busy       <= busy_n;
      layer_done <= layer_done_n;
    end
  end

endmodule
